hpu_ren_sfl_ctrl: RTL and testbench

Speculative free-list controller for the rename stage of hpu_id_ren.
- Holds a PHY_SR_LEN-bit free bitmap (1 = free).
- Grants up to INST_DEC_PARAL physical destination registers per cycle to the rename group.
- Accepts register releases from the commit path.
- On pipeline flush, reloads the bitmap from the architectural free-list recovery vector, then rebuilds the free counter over several cycles before allocation resumes.

---
 rtl/hpu_ren_sfl_ctrl.sv | 148 ++++++++++++++
 tb/tb_hpu_ren_sfl_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hpu_ren_sfl_ctrl.sv
// rtl/hpu_ren_sfl_ctrl.sv - speculative free-list controller for the rename stage
// Grants up to INST_DEC_PARAL free physical registers per cycle; a flush reloads the bitmap and recounts it chunk by chunk.
module hpu_ren_sfl_ctrl #(
  parameter int PHY_SR_LEN     = 64,
  parameter int INST_DEC_PARAL = 2,
  parameter int CNT_CHUNK      = 8,
  parameter int IDX_W          = $clog2(PHY_SR_LEN),
  parameter int CNT_W          = $clog2(PHY_SR_LEN + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                alloc_req_i,
  input  logic [$clog2(INST_DEC_PARAL+1)-1:0] alloc_num_i,
  output logic                                alloc_gnt_o,
  output logic [INST_DEC_PARAL*IDX_W-1:0]     alloc_index_o,
  input  logic [INST_DEC_PARAL-1:0]           release_en_i,
  input  logic [INST_DEC_PARAL*IDX_W-1:0]     release_index_i,
  input  logic                                flush_en_i,
  input  logic [PHY_SR_LEN-1:0]               afl_rcov_data_i,
  output logic [CNT_W-1:0]                    free_cnt_o,
  output logic                                busy_o
);

  localparam int NCHUNK = PHY_SR_LEN / CNT_CHUNK;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NUM_W  = $clog2(INST_DEC_PARAL + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RECOUNT = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [PHY_SR_LEN-1:0]           bitmap_q, bitmap_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;

  logic [INST_DEC_PARAL*IDX_W-1:0] idx_lane;
  logic [CNT_W-1:0]                seen;
  logic [CNT_W-1:0]                rel_cnt;
  logic [CNT_W-1:0]                chunk_cnt;
  logic [CNT_CHUNK-1:0]            chunk_bits;
  logic [CNT_W-1:0]                num_ext;
  logic                            gnt;

  // Lane k picks the (k+1)-th free bit counting up from bit 0.
  always_comb begin
    idx_lane = '0;
    seen     = '0;
    for (int i = 0; i < PHY_SR_LEN; i++) begin
      if (bitmap_q[i]) begin
        for (int k = 0; k < INST_DEC_PARAL; k++) begin
          if (seen == CNT_W'(k)) begin
            idx_lane[k*IDX_W +: IDX_W] = IDX_W'(i);
          end
        end
        seen = seen + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rel_cnt = '0;
    for (int k = 0; k < INST_DEC_PARAL; k++) begin
      if (release_en_i[k]) begin
        rel_cnt = rel_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    chunk_bits = bitmap_q[int'(ptr_q) * CNT_CHUNK +: CNT_CHUNK];
    chunk_cnt  = '0;
    for (int i = 0; i < CNT_CHUNK; i++) begin
      if (chunk_bits[i]) begin
        chunk_cnt = chunk_cnt + CNT_W'(1);
      end
    end
  end

  assign num_ext = CNT_W'(alloc_num_i);

  // The count gate alone keeps free_cnt from underflowing on a grant.
  assign gnt = !rst_i && (state_q == IDLE) && alloc_req_i && !flush_en_i &&
               (cnt_q >= num_ext);

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    if (flush_en_i) begin
      bitmap_d = afl_rcov_data_i;
      cnt_d    = '0;
      ptr_d    = '0;
      state_d  = RECOUNT;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt) begin
            for (int k = 0; k < INST_DEC_PARAL; k++) begin
              if (NUM_W'(k) < alloc_num_i) begin
                bitmap_d[idx_lane[k*IDX_W +: IDX_W]] = 1'b0;
              end
            end
          end
          for (int k = 0; k < INST_DEC_PARAL; k++) begin
            if (release_en_i[k]) begin
              bitmap_d[release_index_i[k*IDX_W +: IDX_W]] = 1'b1;
            end
          end
          cnt_d = cnt_q + rel_cnt - (gnt ? num_ext : '0);
        end
        RECOUNT: begin
          cnt_d = cnt_q + chunk_cnt;
          ptr_d = ptr_q + PTR_W'(1);
          if (ptr_q == PTR_W'(NCHUNK - 1)) begin
            ptr_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bitmap_q <= '1;
      cnt_q    <= CNT_W'(PHY_SR_LEN);
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign alloc_gnt_o   = gnt;
  assign alloc_index_o = idx_lane;
  assign free_cnt_o    = cnt_q;
  assign busy_o        = (state_q == RECOUNT);

endmodule

// File: tb/tb_hpu_ren_sfl_ctrl.sv
// tb/tb_hpu_ren_sfl_ctrl.sv - table-driven bench for hpu_ren_sfl_ctrl
// Inputs change on the falling edge; outputs are compared 1 ns later, before the next rising edge.
module tb_hpu_ren_sfl_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_req_i;
  logic [1:0]  alloc_num_i;
  logic        alloc_gnt_o;
  logic [11:0] alloc_index_o;
  logic [1:0]  release_en_i;
  logic [11:0] release_index_i;
  logic        flush_en_i;
  logic [63:0] afl_rcov_data_i;
  logic [6:0]  free_cnt_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  hpu_ren_sfl_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alloc_req_i     (alloc_req_i),
    .alloc_num_i     (alloc_num_i),
    .alloc_gnt_o     (alloc_gnt_o),
    .alloc_index_o   (alloc_index_o),
    .release_en_i    (release_en_i),
    .release_index_i (release_index_i),
    .flush_en_i      (flush_en_i),
    .afl_rcov_data_i (afl_rcov_data_i),
    .free_cnt_o      (free_cnt_o),
    .busy_o          (busy_o)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [1:0]  num;
    logic [1:0]  rel_en;
    logic [5:0]  ri0;
    logic [5:0]  ri1;
    logic        flush;
    logic [63:0] afl;
    logic        e_gnt;
    logic [1:0]  ck_idx;
    logic [5:0]  e_i0;
    logic [5:0]  e_i1;
    logic        ck_st;
    logic [6:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] shadow = '1;
  vec_t        tbl[26];

  function automatic vec_t mk(input logic rst, input logic req, input logic [1:0] num,
                              input logic [1:0] rel_en, input logic [5:0] ri0, input logic [5:0] ri1,
                              input logic flush, input logic [63:0] afl, input logic e_gnt,
                              input logic [1:0] ck_idx, input logic [5:0] e_i0, input logic [5:0] e_i1,
                              input logic ck_st, input logic [6:0] e_cnt, input logic e_busy);
    vec_t v;
    v.rst = rst; v.req = req; v.num = num; v.rel_en = rel_en; v.ri0 = ri0; v.ri1 = ri1;
    v.flush = flush; v.afl = afl; v.e_gnt = e_gnt; v.ck_idx = ck_idx; v.e_i0 = e_i0;
    v.e_i1 = e_i1; v.ck_st = ck_st; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL v%0d %s: got %0d want %0d", n_vec, nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst_i = 1'b0; alloc_req_i = 1'b0; alloc_num_i = '0; release_en_i = '0;
    release_index_i = '0; flush_en_i = 1'b0; afl_rcov_data_i = '0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_i);
    if (!v.rst && !v.flush && !v.e_busy) begin
      if (v.rel_en[0]) assert (!shadow[v.ri0]) else $error("illegal release of free index %0d", v.ri0);
      if (v.rel_en[1]) assert (!shadow[v.ri1]) else $error("illegal release of free index %0d", v.ri1);
      if (&v.rel_en) assert (v.ri0 != v.ri1) else $error("duplicate release index %0d", v.ri0);
    end
    rst_i = v.rst; alloc_req_i = v.req; alloc_num_i = v.num; release_en_i = v.rel_en;
    release_index_i = {v.ri1, v.ri0}; flush_en_i = v.flush; afl_rcov_data_i = v.afl;
    #1;
    n_vec++;
    chk("gnt", 64'(alloc_gnt_o), 64'(v.e_gnt));
    if (v.ck_idx[0]) chk("idx0", 64'(alloc_index_o[5:0]), 64'(v.e_i0));
    if (v.ck_idx[1]) chk("idx1", 64'(alloc_index_o[11:6]), 64'(v.e_i1));
    if (v.ck_st) begin
      chk("cnt", 64'(free_cnt_o), 64'(v.e_cnt));
      chk("busy", 64'(busy_o), 64'(v.e_busy));
    end
    if (v.rst) shadow = '1;
    else if (v.flush) shadow = v.afl;
    else if (!v.e_busy) begin
      if (v.e_gnt && v.num >= 2'd1) shadow[v.e_i0] = 1'b0;
      if (v.e_gnt && v.num >= 2'd2) shadow[v.e_i1] = 1'b0;
      if (v.rel_en[0]) shadow[v.ri0] = 1'b1;
      if (v.rel_en[1]) shadow[v.ri1] = 1'b1;
    end
  endtask

  initial begin
    int n;
    drive_idle();
    //              rst req num rel   ri0 ri1 fl afl                     gnt ck    i0  i1  st cnt busy
    tbl[0]  = mk(1, 1, 2, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b00, 0,  0,  0, 0,  0);
    tbl[1]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 0,  1,  1, 64, 0);
    tbl[2]  = mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 0,  1,  1, 64, 0);
    tbl[3]  = mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 2,  3,  1, 62, 0);
    tbl[4]  = mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 4,  5,  1, 60, 0);
    tbl[5]  = mk(0, 1, 2, 2'b01, 5, 0, 0, 64'h0,                  1, 2'b11, 6,  7,  1, 58, 0);
    tbl[6]  = mk(0, 1, 1, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 5,  8,  1, 57, 0);
    tbl[7]  = mk(0, 0, 0, 2'b11, 0, 7, 0, 64'h0,                  0, 2'b11, 8,  9,  1, 56, 0);
    tbl[8]  = mk(0, 1, 0, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 0,  7,  1, 58, 0);
    tbl[9]  = mk(0, 1, 2, 2'b00, 0, 0, 1, 64'hF0,                 0, 2'b11, 0,  7,  1, 58, 0);
    tbl[10] = mk(0, 1, 2, 2'b01, 0, 0, 0, 64'h0,                  0, 2'b11, 4,  5,  1, 0,  1);
    for (int i = 11; i < 18; i++)
      tbl[i] = mk(0, 1, 2, 2'b01, 0, 0, 0, 64'h0,                 0, 2'b11, 4,  5,  1, 4,  1);
    tbl[18] = mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0,                  1, 2'b11, 4,  5,  1, 4,  0);
    tbl[19] = mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 6,  7,  1, 2,  0);
    tbl[20] = mk(0, 1, 1, 2'b00, 0, 0, 1, 64'h8000_0000_0000_0001, 0, 2'b11, 6,  7,  1, 2,  0);
    tbl[21] = mk(0, 1, 1, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 0,  63, 1, 0,  1);
    tbl[22] = mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 0,  63, 1, 1,  1);
    tbl[23] = mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 0,  63, 1, 1,  1);
    tbl[24] = mk(1, 1, 1, 2'b00, 0, 0, 1, 64'h0,                  0, 2'b11, 0,  63, 1, 1,  1);
    tbl[25] = mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,                  0, 2'b11, 0,  1,  1, 64, 0);
    foreach (tbl[i]) apply(tbl[i]);

    // Drain all but one register, then probe the last-register boundary.
    for (int i = 0; i < 31; i++)
      apply(mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0, 1, 2'b11, 6'(2*i), 6'(2*i+1), 1, 7'(64-2*i), 0));
    apply(mk(0, 1, 1, 2'b00, 0, 0, 0, 64'h0, 1, 2'b11, 62, 63, 1, 2, 0));
    apply(mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0, 0, 2'b01, 63, 0,  1, 1, 0));
    apply(mk(0, 1, 1, 2'b00, 0, 0, 0, 64'h0, 1, 2'b01, 63, 0,  1, 1, 0));
    apply(mk(0, 1, 1, 2'b00, 0, 0, 0, 64'h0, 0, 2'b00, 0,  0,  1, 0, 0));

    // Re-flush on the fourth recount cycle restarts the count with the new data.
    apply(mk(0, 0, 0, 2'b00, 0, 0, 1, 64'hFF, 0, 2'b00, 0, 0, 1, 0, 0));
    apply(mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,  0, 2'b11, 0, 1, 1, 0, 1));
    apply(mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,  0, 2'b11, 0, 1, 1, 8, 1));
    apply(mk(0, 0, 0, 2'b00, 0, 0, 0, 64'h0,  0, 2'b11, 0, 1, 1, 8, 1));
    apply(mk(0, 1, 1, 2'b00, 0, 0, 1, '1,     0, 2'b11, 0, 1, 1, 8, 1));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      drive_idle();
      #1;
      if (!busy_o) break;
      n++;
    end
    n_vec++;
    chk("busy_len", 64'(n), 64'd8);
    chk("cnt_after_reflush", 64'(free_cnt_o), 64'd64);
    shadow = '1;
    apply(mk(0, 1, 2, 2'b00, 0, 0, 0, 64'h0, 1, 2'b11, 0, 1, 1, 64, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
